// File: rtl/hazard_ctrl.sv
// Pipeline sequencer beside EX: load-use stalls, redirect flush/drain and
// saturating event counters for the IF/DEC/RR stage registers.
module hazard_ctrl #(
   parameter int FLUSH_CYCLES     = 2,
   parameter int LOAD_USE_BUBBLES = 1,
   parameter int CNT_W            = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_mem_stall,
   input  logic             i_ex_load_new_pc,
   input  logic [31:0]      i_ex_new_pc,
   input  logic [6:0]       i_ex_opcode,
   input  logic [4:0]       i_ex_rd_number,
   input  logic [4:0]       i_rr_rs1_number,
   input  logic [4:0]       i_rr_rs2_number,
   input  logic             i_rr_uses_rs1,
   input  logic             i_rr_uses_rs2,
   output logic             o_hold,
   output logic             o_bubble,
   output logic             o_flush,
   output logic             o_redirect_valid,
   output logic [31:0]      o_redirect_pc,
   output logic [1:0]       o_state,
   output logic [CNT_W-1:0] o_redirect_count,
   output logic [CNT_W-1:0] o_bubble_count
);

   localparam int MAX_CNT = (FLUSH_CYCLES > LOAD_USE_BUBBLES) ? FLUSH_CYCLES : LOAD_USE_BUBBLES;
   localparam int CW      = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT + 1);
   localparam logic [6:0] OPC_LOAD = 7'b0000011;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_LDUSE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic             redirect_valid_q;
   logic [31:0]      redirect_pc_q;
   logic [CNT_W-1:0] redirect_count_q;
   logic [CNT_W-1:0] bubble_count_q;
   logic             hazard;

   assign hazard = (i_ex_opcode == OPC_LOAD) && (i_ex_rd_number != 5'd0) &&
                   ((i_rr_uses_rs1 && (i_rr_rs1_number == i_ex_rd_number)) ||
                    (i_rr_uses_rs2 && (i_rr_rs2_number == i_ex_rd_number)));

   // MEM stall overrides everything; otherwise the state decides the controls.
   always_comb begin
      o_hold   = 1'b0;
      o_bubble = 1'b0;
      o_flush  = 1'b0;
      if (!reset) begin
         if (i_mem_stall) begin
            o_hold = 1'b1;
         end else begin
            case (state_q)
               ST_RUN: begin
                  if (i_ex_load_new_pc) begin
                     o_flush = 1'b1;
                  end else if (hazard) begin
                     o_hold   = 1'b1;
                     o_bubble = 1'b1;
                  end
               end
               ST_LDUSE: begin
                  o_hold   = 1'b1;
                  o_bubble = 1'b1;
               end
               ST_DRAIN: o_bubble = 1'b1;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= ST_RUN;
         cnt_q            <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         redirect_count_q <= '0;
         bubble_count_q   <= '0;
      end else begin
         redirect_valid_q <= 1'b0;
         if (!i_mem_stall) begin
            case (state_q)
               ST_RUN: begin
                  if (i_ex_load_new_pc) begin
                     redirect_valid_q <= 1'b1;
                     redirect_pc_q    <= i_ex_new_pc;
                     if (redirect_count_q != '1) redirect_count_q <= redirect_count_q + CNT_W'(1);
                     if (FLUSH_CYCLES > 0) begin
                        state_q <= ST_DRAIN;
                        cnt_q   <= CW'(FLUSH_CYCLES);
                     end
                  end else if (hazard) begin
                     if (bubble_count_q != '1) bubble_count_q <= bubble_count_q + CNT_W'(1);
                     if (LOAD_USE_BUBBLES > 1) begin
                        state_q <= ST_LDUSE;
                        cnt_q   <= CW'(LOAD_USE_BUBBLES - 1);
                     end
                  end
               end
               ST_LDUSE, ST_DRAIN: begin
                  if (bubble_count_q != '1) bubble_count_q <= bubble_count_q + CNT_W'(1);
                  cnt_q <= cnt_q - CW'(1);
                  if (cnt_q == CW'(1)) state_q <= ST_RUN;
               end
               default: state_q <= ST_RUN;
            endcase
         end
      end
   end

   assign o_redirect_valid = redirect_valid_q;
   assign o_redirect_pc    = redirect_pc_q;
   assign o_state          = state_q;
   assign o_redirect_count = redirect_count_q;
   assign o_bubble_count   = bubble_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (default, and 3 load-use bubbles with
// 4-bit counters) checked every cycle against a behavioural model.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_stall, lnp, u1, u2;
   logic [31:0] new_pc;
   logic [6:0]  op;
   logic [4:0]  rd, rs1, rs2;

   logic        hold1, bub1, fl1, rv1;
   logic [31:0] rpc1;
   logic [1:0]  st1;
   logic [15:0] rc1, bc1;
   logic        hold3, bub3, fl3, rv3;
   logic [31:0] rpc3;
   logic [1:0]  st3;
   logic [3:0]  rc3, bc3;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   hazard_ctrl u_dut1 (
      .clk(clk), .reset(reset), .i_mem_stall(mem_stall), .i_ex_load_new_pc(lnp),
      .i_ex_new_pc(new_pc), .i_ex_opcode(op), .i_ex_rd_number(rd),
      .i_rr_rs1_number(rs1), .i_rr_rs2_number(rs2), .i_rr_uses_rs1(u1), .i_rr_uses_rs2(u2),
      .o_hold(hold1), .o_bubble(bub1), .o_flush(fl1), .o_redirect_valid(rv1),
      .o_redirect_pc(rpc1), .o_state(st1), .o_redirect_count(rc1), .o_bubble_count(bc1)
   );

   hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_USE_BUBBLES(3), .CNT_W(4)) u_dut3 (
      .clk(clk), .reset(reset), .i_mem_stall(mem_stall), .i_ex_load_new_pc(lnp),
      .i_ex_new_pc(new_pc), .i_ex_opcode(op), .i_ex_rd_number(rd),
      .i_rr_rs1_number(rs1), .i_rr_rs2_number(rs2), .i_rr_uses_rs1(u1), .i_rr_uses_rs2(u2),
      .o_hold(hold3), .o_bubble(bub3), .o_flush(fl3), .o_redirect_valid(rv3),
      .o_redirect_pc(rpc3), .o_state(st3), .o_redirect_count(rc3), .o_bubble_count(bc3)
   );

   // Model: mode 0 run / 1 load-use / 2 drain, with bubbles still owed.
   typedef struct {
      int          mode;
      int          left;
      bit          rv;
      logic [31:0] rpc;
      int          rcnt;
      int          bcnt;
   } mdl_t;

   mdl_t m1, m3;

   function automatic mdl_t mreset();
      mdl_t r;
      r.mode = 0; r.left = 0; r.rv = 1'b0; r.rpc = '0; r.rcnt = 0; r.bcnt = 0;
      return r;
   endfunction

   function automatic bit is_hz();
      return (op == 7'b0000011) && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
   endfunction

   function automatic mdl_t mnext(mdl_t m, int fc, int lub, int cmax);
      mdl_t n;
      n = m;
      n.rv = 1'b0;
      if (reset) return mreset();
      if (mem_stall) return n;
      if (n.mode == 0) begin
         if (lnp) begin
            n.rv = 1'b1;
            n.rpc = new_pc;
            if (n.rcnt < cmax) n.rcnt++;
            if (fc > 0) begin n.mode = 2; n.left = fc; end
         end else if (is_hz()) begin
            if (n.bcnt < cmax) n.bcnt++;
            if (lub > 1) begin n.mode = 1; n.left = lub - 1; end
         end
      end else begin
         if (n.bcnt < cmax) n.bcnt++;
         n.left--;
         if (n.left == 0) n.mode = 0;
      end
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic chk_dut(input string tag, input mdl_t m,
                          input logic hold, input logic bub, input logic fl, input logic rv,
                          input logic [31:0] rpc, input logic [1:0] st,
                          input logic [31:0] rc, input logic [31:0] bc);
      logic eh, eb, ef;
      eh = 1'b0; eb = 1'b0; ef = 1'b0;
      if (!reset) begin
         if (mem_stall) eh = 1'b1;
         else if (m.mode == 1) begin eh = 1'b1; eb = 1'b1; end
         else if (m.mode == 2) eb = 1'b1;
         else if (lnp) ef = 1'b1;
         else if (is_hz()) begin eh = 1'b1; eb = 1'b1; end
      end
      chk({tag, ".hold"}, 32'(hold), 32'(eh));
      chk({tag, ".bubble"}, 32'(bub), 32'(eb));
      chk({tag, ".flush"}, 32'(fl), 32'(ef));
      chk({tag, ".redirect_valid"}, 32'(rv), 32'(m.rv));
      chk({tag, ".redirect_pc"}, rpc, m.rpc);
      chk({tag, ".state"}, 32'(st), 32'(m.mode));
      chk({tag, ".redirect_count"}, rc, 32'(m.rcnt));
      chk({tag, ".bubble_count"}, bc, 32'(m.bcnt));
   endtask

   // Compare process: inputs change at negedge+1, checks at negedge+3.
   initial begin
      m1 = mreset();
      m3 = mreset();
      forever begin
         @(negedge clk);
         #3;
         if (reset) begin m1 = mreset(); m3 = mreset(); end
         chk_dut("d1", m1, hold1, bub1, fl1, rv1, rpc1, st1, 32'(rc1), 32'(bc1));
         chk_dut("d3", m3, hold3, bub3, fl3, rv3, rpc3, st3, 32'(rc3), 32'(bc3));
         m1 = mnext(m1, 2, 1, 65535);
         m3 = mnext(m3, 2, 3, 15);
      end
   end

   task automatic step(input logic s, input logic l, input logic [31:0] pc, input logic [6:0] o,
                       input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2,
                       input logic a1, input logic a2);
      @(negedge clk);
      #1;
      mem_stall = s; lnp = l; new_pc = pc; op = o; rd = d; rs1 = r1; rs2 = r2; u1 = a1; u2 = a2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 32'h0, 7'h13, 5'd0, 5'd0, 5'd0, 0, 0);
   endtask

   localparam logic [6:0] LD = 7'b0000011;

   initial begin
      reset = 1'b1;
      mem_stall = 0; lnp = 0; new_pc = '0; op = 7'h13; rd = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0;
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      idle(2);
      #3;
      chk("pin reset state", 32'(st1), 32'd0);
      chk("pin reset counts", 32'(rc1) + 32'(bc1), 32'd0);

      // Redirect to 0x100, then two drain bubbles.
      step(0, 1, 32'h0000_0100, 7'h13, 5'd0, 5'd0, 5'd0, 0, 0);
      #3 chk("pin redirect flush", 32'(fl1), 32'd1);
      idle(1);
      #3 chk("pin redirect valid", 32'(rv1), 32'd1);
      chk("pin redirect pc", rpc1, 32'h0000_0100);
      chk("pin drain state", 32'(st1), 32'd2);
      idle(3);
      #3 chk("pin redirect count", 32'(rc1), 32'd1);
      chk("pin bubble count after drain", 32'(bc1), 32'd2);

      // Load-use on rs2, then rd=0 which is never a hazard.
      step(0, 0, 32'h0, LD, 5'd5, 5'd1, 5'd5, 0, 1);
      #3 chk("pin loaduse hold", 32'(hold1), 32'd1);
      chk("pin loaduse bubble", 32'(bub1), 32'd1);
      step(0, 0, 32'h0, LD, 5'd0, 5'd0, 5'd0, 1, 1);
      #3 chk("pin rd0 no hold", 32'(hold1), 32'd0);
      idle(3);

      // Hazard and redirect together: redirect wins.
      step(0, 1, 32'h0000_0200, LD, 5'd6, 5'd6, 5'd0, 1, 0);
      #3 chk("pin both flush", 32'(fl1), 32'd1);
      chk("pin both no hold", 32'(hold1), 32'd0);
      chk("pin both no bubble", 32'(bub1), 32'd0);
      idle(1);
      #3 chk("pin both bubble count", 32'(bc1), 32'd3);
      idle(3);

      // Mem stall across a drain window.
      step(0, 1, 32'hDEAD_BEE0, 7'h13, 5'd0, 5'd0, 5'd0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 32'h0, 7'h13, 5'd0, 5'd0, 5'd0, 0, 0);
         #3 chk("pin stall hold", 32'(hold1), 32'd1);
         chk("pin stall bubble", 32'(bub1), 32'd0);
         chk("pin stall state", 32'(st1), 32'd2);
      end
      idle(3);
      #3 chk("pin bubble count after stall", 32'(bc1), 32'd7);
      chk("pin redirect count after stall", 32'(rc1), 32'd3);

      // Assorted directed patterns.
      step(0, 0, 32'h0, LD, 5'd9, 5'd9, 5'd0, 0, 0);
      step(0, 0, 32'h0, 7'h33, 5'd9, 5'd9, 5'd9, 1, 1);
      step(0, 0, 32'h0, LD, 5'd9, 5'd9, 5'd0, 1, 0);
      step(0, 1, 32'h0000_0400, 7'h13, 5'd0, 5'd0, 5'd0, 0, 0);
      step(0, 1, 32'h0000_0800, 7'h13, 5'd0, 5'd0, 5'd0, 0, 0);
      idle(3);
      step(1, 1, 32'h0000_0C00, LD, 5'd3, 5'd3, 5'd3, 1, 1);
      step(0, 0, 32'h0, LD, 5'd3, 5'd0, 5'd3, 0, 1);
      idle(3);
      for (int i = 0; i < 40; i++) begin
         step(($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
              {$urandom_range(0, 65535), 16'h0}, ($urandom_range(0, 1) != 0) ? LD : 7'h13,
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      idle(4);

      // Back-to-back hazards drive the 4-bit bubble counter into saturation.
      for (int i = 0; i < 20; i++) step(0, 0, 32'h0, LD, 5'd7, 5'd7, 5'd0, 1, 0);
      #3 chk("pin d3 bubble count saturated", 32'(bc3), 32'd15);
      idle(3);

      // Reset in the middle of the load-use window.
      step(0, 0, 32'h0, LD, 5'd8, 5'd0, 5'd8, 0, 1);
      idle(1);
      #3 chk("pin d3 in lduse", 32'(st3), 32'd1);
      @(negedge clk);
      #1 reset = 1'b1;
      #3 chk("pin d3 reset state", 32'(st3), 32'd0);
      chk("pin d3 reset hold", 32'(hold3), 32'd0);
      chk("pin d3 reset bubble", 32'(bub3), 32'd0);
      chk("pin d3 reset bubble count", 32'(bc3), 32'd0);
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      idle(3);
      step(0, 1, 32'h0000_1000, 7'h13, 5'd0, 5'd0, 5'd0, 0, 0);
      idle(4);

      @(negedge clk);
      #4;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
